// File: rtl/button_filter_pkg.sv
// Shared state encoding and cycle-count helpers for the push-button conditioner.
// BF_MS_TO_CYCLES is also meant for divider blocks that need the same ms->cycles rule.
`ifndef BUTTON_FILTER_PKG_SV
`define BUTTON_FILTER_PKG_SV

`define BF_MS_TO_CYCLES(hz, ms) ((64'(hz) / 64'd1000) * 64'(ms))

package button_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_WAIT   = 2'd3
  } bf_state_e;

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned     r = 0;
    longint unsigned x = 64'd1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // A zero-length window would never be satisfied, so clamp to one cycle.
  function automatic longint unsigned ms_to_cycles(input longint unsigned hz,
                                                   input longint unsigned ms);
    longint unsigned c;
    c = `BF_MS_TO_CYCLES(hz, ms);
    return (c == 64'd0) ? 64'd1 : c;
  endfunction

endpackage

`endif

// File: rtl/button_filter_if.sv
// Pad input and conditioned outputs of the button filter.
// master drives the pad (board / bench side), slave is the filter itself.
interface button_filter_if;
  logic pad_btn;
  logic pressed;
  logic press;
  logic release_stb;
  logic long;
  logic held_long;

  modport master (
    output pad_btn,
    input  pressed, press, release_stb, long, held_long
  );

  modport slave (
    input  pad_btn,
    output pressed, press, release_stb, long, held_long
  );
endinterface

// File: rtl/button_filter_sync2.sv
// Two-flop synchroniser for an asynchronous pad, reset to RST_VAL.
// Latency: 2 clock edges. Backpressure: none, samples every cycle.
module button_filter_sync2 #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_filter.sv
// Debounced level, press/release strobes and long-press detection for a raw button pad.
// Latency: 2+DEB edges pad->press/release, LNG edges press->long. Backpressure: none.
module button_filter
  import button_filter_pkg::*;
#(
  parameter int unsigned CLOCK       = 25_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic           clock,
  input  logic           reset_n,
  button_filter_if.slave bus
);

  localparam longint unsigned DEB = ms_to_cycles(64'(CLOCK), 64'(DEBOUNCE_MS));
  localparam longint unsigned LNG = ms_to_cycles(64'(CLOCK), 64'(LONG_MS));
  localparam int unsigned     CW  = clog2((DEB > LNG) ? DEB : LNG) + 1;

  localparam logic [CW-1:0] DEB_M1 = CW'(DEB - 64'd1);
  localparam logic [CW-1:0] LNG_M1 = CW'(LNG - 64'd1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic raw;
  logic s;

  assign raw = bus.pad_btn ^ ACTIVE_LOW;

  button_filter_sync2 #(.RST_VAL(1'b0)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (raw),
    .q       (s)
  );

  bf_state_e     state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic          long_done_q, long_done_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          dcnt_d  = ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q >= DEB_M1) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          lcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end
      ST_PRESSED: begin
        // The long strobe fires even if the pad lets go on the same cycle.
        if (!long_done_q) begin
          if (lcnt_q >= LNG_M1) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end else if (s) begin
            lcnt_d = lcnt_q + ONE;
          end
        end
        if (!s) begin
          state_d = ST_REL_WAIT;
          dcnt_d  = ONE;
        end
      end
      ST_REL_WAIT: begin
        if (s) begin
          state_d = ST_PRESSED;
        end else if (dcnt_q >= DEB_M1) begin
          state_d     = ST_IDLE;
          release_d   = 1'b1;
          long_done_d = 1'b0;
          lcnt_d      = '0;
          dcnt_d      = '0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pressed_d = (state_d == ST_PRESSED) || (state_d == ST_REL_WAIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dcnt_q      <= '0;
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      pressed_q   <= pressed_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign bus.pressed     = pressed_q;
  assign bus.press       = press_q;
  assign bus.release_stb = release_q;
  assign bus.long        = long_q;
  assign bus.held_long   = long_done_q;

endmodule
